mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Memory controller sitting between the core's IF stage, the MEM stage and the single byte-wide RAM port.
- Arbitrates fetch vs. load/store requests.
- Sequences 1/2/4-byte accesses as byte transfers in little-endian order.
- Returns assembled 32-bit results with a one-cycle completion pulse.
- The MEM-side handshake is addr_needed / mem_available / mem_working.

Parameters:
- ADDR_WIDTH, 32, width of all byte addresses
- FETCH_BYTES, 4, bytes per instruction fetch (fixed word fetch)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high (`RstEnable = 1)
- rdy  in  1  global ready; low freezes all state and outputs
- if_req  in  1  fetch request, level, held until if_done or if_flush
- if_addr  in  32  fetch byte address
- if_flush  in  1  abandon any in-flight fetch (branch redirect)
- if_data  out  32  fetched instruction word
- if_done  out  1  one-cycle pulse, if_data valid
- addr_mem  in  32  MEM-stage byte address
- wr_mem  in  1  0 load, 1 store
- data_mem  in  32  store data; low bytes used
- cnf_mem  in  2  0 none, 1 B, 2 H, 3 W
- addr_needed  out  1  controller idle, will accept a MEM request this cycle
- mem_working  out  1  MEM op in progress
- mem_available  out  1  one-cycle pulse, MEM op complete
- data_in  out  32  load result, raw, zero-filled above width; sign handling is done by the MEM stage
- ram_din  in  8  RAM read byte, valid the cycle after its address
- ram_dout  out  8  RAM write byte
- ram_a  out  32  RAM byte address
- ram_wr  out  1  1 write, 0 read

Behaviour:
- State machine: IDLE, IF_RD, MEM_RD, MEM_WR. Byte counter cnt 0..4. Latched addr, data, length n (B=1, H=2, W=4), and a result shift register.
- Reset (at clk edge with rst=1), including mid-operation:
  - state=IDLE, cnt=0.
  - All outputs 0: ram_wr=0, ram_a=0, if_done=0, mem_available=0, mem_working=0, data_in=0, if_data=0.
  - No RAM write is issued after the reset edge.
- rdy=0: no register changes; ram_wr forced 0.
- Acceptance, at edge A, in IDLE only:
  - cnf_mem!=0 has priority over if_req.
  - addr_needed = (state==IDLE) && !rst.
  - if_req is accepted only if cnf_mem==0 and if_flush==0.
- Read, n bytes (IF uses n=FETCH_BYTES):
  - Cycles A+1..A+n drive ram_a=addr+k, ram_wr=0.
  - Byte k is captured from ram_din in cycle A+2+k into bits [8k+7:8k].
  - Completion pulse in cycle A+n+2 with data held stable afterwards.
  - Load of 4 bytes has 6-cycle latency from accept to pulse.
- Write, n bytes:
  - Cycles A+1..A+n drive ram_wr=1, ram_a=addr+k, ram_dout=data_mem[8k+7:8k].
  - mem_available pulses in cycle A+n+1.
  - data_in is left unchanged.
- Completion cycle:
  - state is already IDLE and addr_needed=1, so back-to-back requests are accepted with zero bubble.
  - Between transfers ram_wr=0.
- mem_working:
  - 1 from cycle A+1 through the cycle before mem_available.
  - 0 in the mem_available cycle.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- if_flush:
  - In IF_RD: return to IDLE on the next edge, no if_done, result discarded.
  - In IDLE: suppresses acceptance of if_req.
  - No effect on MEM ops; MEM ops are never aborted.
- Simultaneous if_req and cnf_mem in IDLE:
  - MEM is served first.
  - The fetch is accepted at the MEM completion cycle or later if still requested.
- Requests arriving while busy are not latched; requesters hold their inputs.

Decomposition:
- Add to defines.v:
  - state encodings (`MemCtrlIdle, `MemCtrlIfRd, `MemCtrlMemRd, `MemCtrlMemWr)
  - cnf codes (`CnfNone=0, `CnfB=1, `CnfH=2, `CnfW=3)
  - `RamDataBus (7:0)
- Byte-length decode (cnf → n) is a shared function.
- No sub-module: the byte sequencer is a single FSM plus counter.

Test Plan:
- IF word: if_addr=0x100, RAM bytes 13,05,10,00 → if_data=0x00100513, if_done exactly at accept+6, ram_wr=0 throughout.
- MEM store H: addr=0x2002, data_mem=0xDEADBEEF, cnf=2, wr=1 → writes EF@0x2002 and BE@0x2003, no other writes, mem_available at accept+3, mem_working high for 2 cycles.
- MEM load B: addr=0x7, RAM[7]=0x80 → data_in=0x00000080, mem_available at accept+3.
- Contention: if_req and cnf_mem=3 (load) asserted in the same IDLE cycle → MEM served first; fetch accepted in the mem_available cycle; if_done follows 6 cycles later.
- Flush/reset mid-op:
  - if_flush in the 3rd cycle of IF_RD → no if_done, addr_needed=1 next cycle.
  - rst during a W store after 2 bytes → bytes 2 and 3 are never written, all outputs 0.
- rdy gating: drop rdy for 3 cycles mid-W-load → result and pulse delayed by exactly 3 cycles, data unchanged.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-serial memory controller.
// State encodings, access-size codes and the size-to-length decode.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        MC_IDLE,
        MC_IF_RD,
        MC_MEM_RD,
        MC_MEM_WR
    } mc_state_t;

    localparam logic [1:0] CNF_NONE = 2'd0;
    localparam logic [1:0] CNF_B    = 2'd1;
    localparam logic [1:0] CNF_H    = 2'd2;
    localparam logic [1:0] CNF_W    = 2'd3;

    localparam int RAM_DW = 8;

    // Access size code to byte count.
    function automatic logic [2:0] cnf_len(input logic [1:0] cnf);
        logic [2:0] n;
        case (cnf)
            CNF_B:   n = 3'd1;
            CNF_H:   n = 3'd2;
            CNF_W:   n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates IF fetches and MEM loads/stores onto a
// single byte-wide RAM port, sequencing little-endian byte transfers.
// Ports:
//   clk, rst (sync, active-high), rdy (global freeze when low)
//   if_req/if_addr/if_flush -> if_data/if_done   : instruction fetch
//   addr_mem/wr_mem/data_mem/cnf_mem             : MEM request
//   addr_needed/mem_working/mem_available/data_in: MEM handshake/result
//   ram_din/ram_dout/ram_a/ram_wr                : byte RAM port
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int FETCH_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,

    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  if_flush,
    output logic [31:0]           if_data,
    output logic                  if_done,

    input  logic [ADDR_WIDTH-1:0] addr_mem,
    input  logic                  wr_mem,
    input  logic [31:0]           data_mem,
    input  logic [1:0]            cnf_mem,
    output logic                  addr_needed,
    output logic                  mem_working,
    output logic                  mem_available,
    output logic [31:0]           data_in,

    input  logic [RAM_DW-1:0]     ram_din,
    output logic [RAM_DW-1:0]     ram_dout,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic                  ram_wr
);

    localparam logic [2:0] FETCH_N = 3'(FETCH_BYTES);

    mc_state_t             state;
    logic [2:0]            cnt;     // addresses issued so far
    logic [1:0]            rcnt;    // bytes captured so far
    logic [2:0]            n;
    logic                  iss;     // ram_a holds a live read address
    logic                  vld;     // ram_din carries a byte to capture
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           res;
    logic [31:0]           cap;
    logic                  ram_wr_q;

    assign addr_needed = (state == MC_IDLE) && !rst;
    assign ram_wr      = ram_wr_q & rdy;

    // Result with the incoming byte merged at its little-endian slot.
    always_comb begin
        cap = res;
        cap[{rcnt, 3'b000} +: 8] = ram_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= MC_IDLE;
            cnt           <= '0;
            rcnt          <= '0;
            n             <= '0;
            iss           <= 1'b0;
            vld           <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            res           <= '0;
            ram_wr_q      <= 1'b0;
            ram_a         <= '0;
            ram_dout      <= '0;
            if_data       <= '0;
            if_done       <= 1'b0;
            data_in       <= '0;
            mem_available <= 1'b0;
            mem_working   <= 1'b0;
        end else if (rdy) begin
            if_done       <= 1'b0;
            mem_available <= 1'b0;
            unique case (state)
                MC_IDLE: begin
                    if (cnf_mem != CNF_NONE) begin
                        state       <= wr_mem ? MC_MEM_WR : MC_MEM_RD;
                        n           <= cnf_len(cnf_mem);
                        addr_q      <= addr_mem;
                        wdata_q     <= data_mem;
                        cnt         <= 3'd1;
                        rcnt        <= '0;
                        res         <= '0;
                        iss         <= !wr_mem;
                        vld         <= 1'b0;
                        ram_a       <= addr_mem;
                        ram_dout    <= data_mem[7:0];
                        ram_wr_q    <= wr_mem;
                        mem_working <= 1'b1;
                    end else if (if_req && !if_flush) begin
                        state    <= MC_IF_RD;
                        n        <= FETCH_N;
                        addr_q   <= if_addr;
                        cnt      <= 3'd1;
                        rcnt     <= '0;
                        res      <= '0;
                        iss      <= 1'b1;
                        vld      <= 1'b0;
                        ram_a    <= if_addr;
                        ram_wr_q <= 1'b0;
                    end
                end

                MC_IF_RD, MC_MEM_RD: begin
                    if (state == MC_IF_RD && if_flush) begin
                        state <= MC_IDLE;
                        cnt   <= '0;
                        iss   <= 1'b0;
                        vld   <= 1'b0;
                    end else begin
                        // Address issue runs one cycle ahead of capture.
                        vld <= iss;
                        if (cnt < n) begin
                            ram_a <= addr_q + ADDR_WIDTH'(cnt);
                            cnt   <= cnt + 3'd1;
                            iss   <= 1'b1;
                        end else begin
                            iss <= 1'b0;
                        end
                        if (vld) begin
                            res  <= cap;
                            rcnt <= rcnt + 2'd1;
                            if ({1'b0, rcnt} == n - 3'd1) begin
                                state <= MC_IDLE;
                                cnt   <= '0;
                                iss   <= 1'b0;
                                vld   <= 1'b0;
                                if (state == MC_IF_RD) begin
                                    if_data <= cap;
                                    if_done <= 1'b1;
                                end else begin
                                    data_in       <= cap;
                                    mem_available <= 1'b1;
                                    mem_working   <= 1'b0;
                                end
                            end
                        end
                    end
                end

                MC_MEM_WR: begin
                    if (cnt < n) begin
                        ram_a    <= addr_q + ADDR_WIDTH'(cnt);
                        ram_dout <= wdata_q[{cnt[1:0], 3'b000} +: 8];
                        cnt      <= cnt + 3'd1;
                    end else begin
                        ram_wr_q      <= 1'b0;
                        state         <= MC_IDLE;
                        cnt           <= '0;
                        mem_available <= 1'b1;
                        mem_working   <= 1'b0;
                    end
                end

                default: state <= MC_IDLE;
            endcase
        end
    end

endmodule
